// File: rtl/weight_sched_ctrl_pkg.sv
// Shared field widths and tile geometry for the weight scheduler.
package weight_sched_ctrl_pkg;
  localparam int S2P_SIZE         = 8;
  localparam int KERNEL_SIZE      = 4;
  localparam int CHANNELS_SIZE    = 8;
  localparam int KERNEL_NUMS_SIZE = 8;
  localparam int S2P_LOG2         = $clog2(S2P_SIZE);
  localparam int W_WIDTH          = 2*KERNEL_SIZE + CHANNELS_SIZE;
  localparam int ELEM_WIDTH       = 2*S2P_LOG2;
endpackage

// File: rtl/weight_sched_ctrl_tile_cfg_calc.sv
// Two-step tile geometry: step1 registers W=K*K*C, step2 registers the derived tile counts.
// S2P is a power of two, so every div/mod below is a shift or a mask.
module tile_cfg_calc import weight_sched_ctrl_pkg::*; (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        step1,
  input  logic                        step2,
  input  logic [KERNEL_SIZE-1:0]      kernel_size,
  input  logic [CHANNELS_SIZE-1:0]    channels,
  input  logic [KERNEL_NUMS_SIZE-1:0] kernel_nums,
  output logic [W_WIDTH-1:0]          img2col_w_width,
  output logic [W_WIDTH-1:0]          buffer_col_nums,
  output logic [KERNEL_NUMS_SIZE-1:0] buffer_row_nums,
  output logic [S2P_SIZE-1:0]         img2col_w_width_rem,
  output logic [S2P_SIZE-1:0]         kernel_nums_rem
);
  logic [W_WIDTH-1:0]  w_q;
  logic [S2P_LOG2-1:0] w_mod;
  logic [S2P_LOG2-1:0] n_mod;

  assign w_mod = w_q[S2P_LOG2-1:0];
  assign n_mod = kernel_nums[S2P_LOG2-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q                 <= '0;
      img2col_w_width     <= '0;
      buffer_col_nums     <= '0;
      buffer_row_nums     <= '0;
      img2col_w_width_rem <= '0;
      kernel_nums_rem     <= '0;
    end else begin
      if (step1)
        w_q <= W_WIDTH'(kernel_size) * W_WIDTH'(kernel_size) * W_WIDTH'(channels);
      if (step2) begin
        img2col_w_width     <= w_q;
        // ceil(W/S2P)-1: add one tile when any remainder bits are set
        buffer_col_nums     <= (w_q >> S2P_LOG2) + W_WIDTH'(|w_mod) - W_WIDTH'(1);
        buffer_row_nums     <= (kernel_nums >> S2P_LOG2) + KERNEL_NUMS_SIZE'(|n_mod);
        img2col_w_width_rem <= S2P_SIZE'(w_mod) - S2P_SIZE'(1);
        kernel_nums_rem     <= S2P_SIZE'(n_mod) - S2P_SIZE'(1);
      end
    end
  end
endmodule

// File: rtl/weight_sched_ctrl.sv
// Weight-stream scheduler: latches a job, derives tile geometry, then paces the weight
// address generator one element per s2p_ready through elem/col/pass/row loops.
module weight_sched_ctrl import weight_sched_ctrl_pkg::*; (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [KERNEL_SIZE-1:0]      cfg_kernel_size,
  input  logic [CHANNELS_SIZE-1:0]    cfg_channels,
  input  logic [KERNEL_NUMS_SIZE-1:0] cfg_kernel_nums,
  input  logic [KERNEL_NUMS_SIZE-1:0] cfg_img_passes,
  input  logic                        s2p_ready,
  input  logic                        abort,
  output logic                        enable,
  output logic                        tensor_done,
  output logic [W_WIDTH-1:0]          buffer_col_nums,
  output logic [KERNEL_NUMS_SIZE-1:0] buffer_row_nums,
  output logic [W_WIDTH-1:0]          img2col_w_width,
  output logic [S2P_SIZE-1:0]         kernel_nums_rem,
  output logic [S2P_SIZE-1:0]         img2col_w_width_rem,
  output logic                        busy,
  output logic                        done
);
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CALC  = 5'b00010,
    RUN   = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  localparam logic [ELEM_WIDTH-1:0] ELEM_MAX = ELEM_WIDTH'(S2P_SIZE*S2P_SIZE - 1);

  state_t                      state;
  logic                        calc_second;
  logic [KERNEL_SIZE-1:0]      k_q;
  logic [CHANNELS_SIZE-1:0]    c_q;
  logic [KERNEL_NUMS_SIZE-1:0] n_q;
  logic [KERNEL_NUMS_SIZE-1:0] p_q;

  logic [ELEM_WIDTH-1:0]       elem, elem_nxt;
  logic [W_WIDTH-1:0]          col, col_nxt;
  logic [KERNEL_NUMS_SIZE-1:0] pass, pass_nxt;
  logic [KERNEL_NUMS_SIZE-1:0] row, row_nxt;
  logic [KERNEL_NUMS_SIZE-1:0] p_m1, rows_m1;
  logic elem_last, col_last, pass_last, row_last, job_last;
  logic step1, step2;

  assign enable    = (state == RUN) && s2p_ready;
  assign p_m1      = p_q - 1'b1;
  assign rows_m1   = buffer_row_nums - 1'b1;
  assign elem_last = (elem == ELEM_MAX);
  assign col_last  = (col == buffer_col_nums);
  assign pass_last = (pass == p_m1);
  assign row_last  = (row == rows_m1);
  assign job_last  = enable && elem_last && col_last && pass_last && row_last;
  // abort gating keeps the previous job's geometry intact when CALC is killed
  assign step1     = (state == CALC) && !calc_second && !abort;
  assign step2     = (state == CALC) &&  calc_second && !abort;

  always_comb begin
    elem_nxt = elem;
    col_nxt  = col;
    pass_nxt = pass;
    row_nxt  = row;
    if (enable) begin
      elem_nxt = elem_last ? '0 : elem + 1'b1;
      if (elem_last) begin
        col_nxt = col_last ? '0 : col + 1'b1;
        if (col_last) begin
          pass_nxt = pass_last ? '0 : pass + 1'b1;
          if (pass_last)
            row_nxt = row_last ? '0 : row + 1'b1;
        end
      end
    end
  end

  tile_cfg_calc u_calc (
    .clk                 (clk),
    .rstn                (rstn),
    .step1               (step1),
    .step2               (step2),
    .kernel_size         (k_q),
    .channels            (c_q),
    .kernel_nums         (n_q),
    .img2col_w_width     (img2col_w_width),
    .buffer_col_nums     (buffer_col_nums),
    .buffer_row_nums     (buffer_row_nums),
    .img2col_w_width_rem (img2col_w_width_rem),
    .kernel_nums_rem     (kernel_nums_rem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      calc_second <= 1'b0;
      k_q         <= '0;
      c_q         <= '0;
      n_q         <= '0;
      p_q         <= '0;
      elem        <= '0;
      col         <= '0;
      pass        <= '0;
      row         <= '0;
      tensor_done <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        calc_second <= 1'b0;
        elem        <= '0;
        col         <= '0;
        pass        <= '0;
        row         <= '0;
        tensor_done <= 1'b0;
        busy        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              k_q         <= cfg_kernel_size;
              c_q         <= cfg_channels;
              n_q         <= cfg_kernel_nums;
              p_q         <= cfg_img_passes;
              calc_second <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end
          end
          CALC: begin
            calc_second <= !calc_second;
            if (calc_second) begin
              elem        <= '0;
              col         <= '0;
              pass        <= '0;
              row         <= '0;
              // pass starts at 0, so a single-pass job is on its last pass immediately
              tensor_done <= (p_m1 == '0);
              state       <= RUN;
            end
          end
          RUN: begin
            elem <= elem_nxt;
            col  <= col_nxt;
            pass <= pass_nxt;
            row  <= row_nxt;
            if (job_last) begin
              tensor_done <= 1'b0;
              state       <= DRAIN;
            end else begin
              tensor_done <= (pass_nxt == p_m1);
            end
          end
          DRAIN: begin
            done  <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_weight_sched_ctrl.sv
// Directed bench for weight_sched_ctrl: geometry, enable counts, tensor_done, abort, reset.
module tb_weight_sched_ctrl;
  import weight_sched_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        rstn = 1'b1;
  logic                        start = 1'b0;
  logic                        s2p_ready = 1'b0;
  logic                        abort = 1'b0;
  logic [KERNEL_SIZE-1:0]      cfg_kernel_size = '0;
  logic [CHANNELS_SIZE-1:0]    cfg_channels = '0;
  logic [KERNEL_NUMS_SIZE-1:0] cfg_kernel_nums = '0;
  logic [KERNEL_NUMS_SIZE-1:0] cfg_img_passes = '0;
  logic                        enable, tensor_done, busy, done;
  logic [W_WIDTH-1:0]          buffer_col_nums, img2col_w_width;
  logic [KERNEL_NUMS_SIZE-1:0] buffer_row_nums;
  logic [S2P_SIZE-1:0]         kernel_nums_rem, img2col_w_width_rem;

  int n_checks = 0;
  int n_errors = 0;

  weight_sched_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .cfg_kernel_size     (cfg_kernel_size),
    .cfg_channels        (cfg_channels),
    .cfg_kernel_nums     (cfg_kernel_nums),
    .cfg_img_passes      (cfg_img_passes),
    .s2p_ready           (s2p_ready),
    .abort               (abort),
    .enable              (enable),
    .tensor_done         (tensor_done),
    .buffer_col_nums     (buffer_col_nums),
    .buffer_row_nums     (buffer_row_nums),
    .img2col_w_width     (img2col_w_width),
    .kernel_nums_rem     (kernel_nums_rem),
    .img2col_w_width_rem (img2col_w_width_rem),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string name, input int k, input int c, input int n, input int p,
                         input int exp_w, input int exp_col, input int exp_wrem,
                         input int exp_rows, input int exp_krem,
                         input bit rand_ready, input int abort_at, input bit spam_start);
    int total, cnt, budget, td_err, en_err, done_seen;
    int m_elem, m_col, m_pass;
    total = exp_rows * p * (exp_col + 1) * S2P_SIZE * S2P_SIZE;
    cnt = 0; budget = 0; td_err = 0; en_err = 0; done_seen = 0;
    m_elem = 0; m_col = 0; m_pass = 0;

    @(negedge clk);
    cfg_kernel_size = KERNEL_SIZE'(k);
    cfg_channels    = CHANNELS_SIZE'(c);
    cfg_kernel_nums = KERNEL_NUMS_SIZE'(n);
    cfg_img_passes  = KERNEL_NUMS_SIZE'(p);
    s2p_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // config scrambled after start must not affect the running job
    cfg_kernel_size = KERNEL_SIZE'($urandom);
    cfg_channels    = CHANNELS_SIZE'($urandom);
    cfg_kernel_nums = KERNEL_NUMS_SIZE'($urandom);
    cfg_img_passes  = KERNEL_NUMS_SIZE'($urandom_range(1, 5));
    check({name, "_busy_start"}, 32'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    check({name, "_w"},    32'(img2col_w_width), exp_w);
    check({name, "_col"},  32'(buffer_col_nums), exp_col);
    check({name, "_wrem"}, 32'(img2col_w_width_rem), exp_wrem);
    check({name, "_rows"}, 32'(buffer_row_nums), exp_rows);
    check({name, "_krem"}, 32'(kernel_nums_rem), exp_krem);

    while (cnt < total && budget < 20000) begin
      if (abort_at >= 0 && cnt == abort_at) begin
        abort = 1'b1;
        s2p_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        s2p_ready = 1'b1;
        #1;
        check({name, "_abort_enable"}, 32'(enable), 0);
        check({name, "_abort_busy"}, 32'(busy), 0);
        check({name, "_abort_td"}, 32'(tensor_done), 0);
        check({name, "_abort_w_kept"}, 32'(img2col_w_width), exp_w);
        for (int i = 0; i < 5; i++) begin
          if (done) done_seen++;
          @(negedge clk);
        end
        s2p_ready = 1'b0;
        check({name, "_abort_no_done"}, 32'(done_seen), 0);
        return;
      end
      s2p_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (spam_start && (budget % 97 == 5)) ? 1'b1 : 1'b0;
      #1;
      if (enable !== s2p_ready) en_err++;
      if (done) en_err++;
      if (tensor_done !== (m_pass == p - 1)) td_err++;
      if (enable) begin
        cnt++;
        m_elem++;
        if (m_elem == S2P_SIZE * S2P_SIZE) begin
          m_elem = 0;
          m_col++;
          if (m_col == exp_col + 1) begin
            m_col = 0;
            m_pass++;
            if (m_pass == p) m_pass = 0;
          end
        end
      end
      budget++;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_enable_count"}, 32'(cnt), 32'(total));
    check({name, "_td_errs"}, 32'(td_err), 0);
    check({name, "_en_errs"}, 32'(en_err), 0);
    s2p_ready = 1'b1;
    #1;
    check({name, "_drain_enable"}, 32'(enable), 0);
    check({name, "_drain_done"}, 32'(done), 0);
    @(negedge clk);
    #1;
    check({name, "_done_pulse"}, 32'(done), 1);
    check({name, "_done_busy"}, 32'(busy), 1);
    @(negedge clk);
    #1;
    check({name, "_done_once"}, 32'(done), 0);
    check({name, "_idle_busy"}, 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check({name, "_no_extra_job"}, 32'(done_seen), 0);
    s2p_ready = 1'b0;
  endtask

  initial begin
    #2 rstn = 1'b0;
    @(negedge clk);
    check("rst_enable", 32'(enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_td", 32'(tensor_done), 0);
    check("rst_w", 32'(img2col_w_width), 0);
    check("rst_col", 32'(buffer_col_nums), 0);
    @(negedge clk);
    rstn = 1'b1;

    run_job("c1",  3, 4, 10, 2, 36, 4, 3, 2, 1, 1'b0, -1, 1'b0);
    run_job("c2",  2, 16, 16, 1, 64, 7, 255, 2, 255, 1'b0, -1, 1'b0);
    run_job("c1r", 3, 4, 10, 2, 36, 4, 3, 2, 1, 1'b1, -1, 1'b0);
    run_job("c1a", 3, 4, 10, 2, 36, 4, 3, 2, 1, 1'b0, 500, 1'b0);
    run_job("c1b", 3, 4, 10, 2, 36, 4, 3, 2, 1, 1'b0, -1, 1'b0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("idle_abort_busy", 32'(busy), 0);

    // reset in the middle of RUN
    @(negedge clk);
    cfg_kernel_size = 4'd3;
    cfg_channels    = 8'd4;
    cfg_kernel_nums = 8'd10;
    cfg_img_passes  = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s2p_ready = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    check("mid_enable", 32'(enable), 1);
    rstn = 1'b0;
    #1;
    check("rst_mid_enable", 32'(enable), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_td", 32'(tensor_done), 0);
    check("rst_mid_w", 32'(img2col_w_width), 0);
    check("rst_mid_rows", 32'(buffer_row_nums), 0);
    check("rst_mid_krem", 32'(kernel_nums_rem), 0);
    @(negedge clk);
    rstn = 1'b1;
    s2p_ready = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);

    run_job("c1s", 3, 4, 10, 2, 36, 4, 3, 2, 1, 1'b0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
